// File: rtl/isram_pkg.sv
// ----------------------------------------------------------------------------
// isram_pkg
//
// Shared definitions for the instruction-SRAM fetch front end.
//   ILEN              : width of one RV32 instruction
//   WORD_W            : width of one isram read word (two instructions)
//   BANK_LO / BANK_HI : lane index of each bank inside a 64-bit read word
//   DEFAULT_RESET_PC  : fetch PC used after reset unless overridden
//   lane_t            : which lanes of an in-flight read are pushed
//   fetch_entry_t     : one FIFO entry, an instruction tagged with its PC
// ----------------------------------------------------------------------------
package isram_pkg;

    localparam int ILEN   = 32;
    localparam int WORD_W = 64;

    localparam int BANK_LO = 0;
    localparam int BANK_HI = 1;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // A read always returns a full 64-bit word.  A fetch PC with bit 2 clear
    // uses both instructions of the word; with bit 2 set only the upper one.
    typedef enum logic {
        LANE_BOTH = 1'b0,
        LANE_HI   = 1'b1
    } lane_t;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Base address of the 64-bit word that contains pc.
    function automatic logic [31:0] word_base(input logic [31:0] pc);
        return pc & 32'hFFFF_FFF8;
    endfunction

    // Fetch PC that follows a read at pc: the start of the next word, so an
    // odd (bit 2 set) PC advances by 4 and an even one by 8.  Wraps at 2^32.
    function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
        return word_base(pc) + 32'd8;
    endfunction

endpackage

// File: rtl/isfetch_fifo.sv
// ----------------------------------------------------------------------------
// isfetch_fifo
//
// Circular instruction queue for the fetch front end.  Accepts up to two
// entries per cycle (first, then second, in order) and releases one entry
// per cycle from the head.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   flush        : empties the queue this edge; wins over push and pop
//   push_first   : write first_entry at the tail
//   push_second  : write second_entry behind first_entry (needs push_first)
//   first_entry  : entry written by push_first
//   second_entry : entry written by push_second
//   pop          : consume the head entry (ignored when empty)
//   head         : head entry, all zeros when the queue is empty
//   count        : number of valid entries, 0..DEPTH
// ----------------------------------------------------------------------------
module isfetch_fifo
    import isram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push_first,
    input  logic                         push_second,
    input  fetch_entry_t                 first_entry,
    input  fetch_entry_t                 second_entry,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_pop;
    logic [1:0]     push_num;

    // A flush discards everything, so a pop in the same cycle is meaningless.
    assign do_pop   = pop && (count != '0) && !flush;
    assign push_num = {1'b0, push_first} + {1'b0, push_second};

    // Storage carries no reset: an entry is only ever read after it has been
    // written, and the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push_first && !flush) begin
            mem[wr_ptr] <= first_entry;
        end
        if (push_second && !flush) begin
            mem[wr_ptr + PW'(1)] <= second_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the count is
    // the only thing that distinguishes a full queue from an empty one.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_num);
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_num) - CW'(do_pop);
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/isram_fetch.sv
// ----------------------------------------------------------------------------
// isram_fetch
//
// Instruction-fetch front end for the two-bank 64-bit instruction SRAM.
// Each read returns one 64-bit word that is split into one or two RV32
// instructions, queued in isfetch_fifo and handed to decode over valid/ready.
// A redirect flushes the queue, drops any read in flight and restarts fetch.
//
// Build option:
//   ISFETCH_BANK_GATE_EN : when defined, only the banks actually needed by a
//                          read are selected (bank0 is skipped for a fetch
//                          PC with bit 2 set).  When undefined both banks are
//                          selected on every read.  The queued instructions
//                          are the same either way.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset, highest priority
//   redirect_valid : restart fetch at redirect_pc
//   redirect_pc    : new fetch PC, bits [1:0] ignored
//   instr_valid    : queue head holds an instruction
//   instr_ready    : decode accepts the head
//   instr_data     : instruction at the head
//   instr_pc       : PC of instr_data
//   isram_csn0     : bank0 (low word) select, active low
//   isram_csn1     : bank1 (high word) select, active low
//   isram_wen      : write enable, active low, tied inactive
//   isram_addr     : 64-bit word index of the read
//   isram_dout     : read data, valid the cycle after the select
// ----------------------------------------------------------------------------
module isram_fetch
    import isram_pkg::*;
#(
    parameter int          AW       = 16,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ILEN-1:0]   instr_data,
    output logic [31:0]       instr_pc,
    output logic              isram_csn0,
    output logic              isram_csn1,
    output logic              isram_wen,
    output logic [AW-1:0]     isram_addr,
    input  logic [WORD_W-1:0] isram_dout
);

    localparam int CW = $clog2(DEPTH + 1);

    // A read may bring back two instructions, so it is only started when the
    // queue is guaranteed to have room for both.
    localparam int ISSUE_MIN_FREE = 2;

    logic [31:0]   pc;
    logic          inflight;
    lane_t         infl_lane;
    logic [31:0]   infl_pc;

    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  first_entry;
    fetch_entry_t  second_entry;
    logic          push_first;
    logic          push_second;
    logic          pop;
    logic          issue;
    logic [1:0]    infl_words;
    logic [31:0]   used_slots;

    // Slots already spoken for: entries in the queue plus the words of the
    // read in flight, which land this cycle.  Pops in the current cycle are
    // not credited, which keeps the check simple and still allows one
    // instruction per cycle to stream through a four-entry queue.
    always_comb begin
        infl_words = 2'd0;
        if (inflight) begin
            infl_words = (infl_lane == LANE_BOTH) ? 2'd2 : 2'd1;
        end
    end

    assign used_slots = 32'(count) + 32'(infl_words);
    assign issue      = !rst && !redirect_valid
                        && (used_slots + 32'(ISSUE_MIN_FREE) <= 32'(DEPTH));

    // The address is parked at zero when idle so the bus is quiet.
    assign isram_addr = issue ? pc[AW+2:3] : '0;
    assign isram_wen  = 1'b1;

`ifdef ISFETCH_BANK_GATE_EN
    // Bank0 holds the low instruction, which an odd fetch PC never uses.
    assign isram_csn0 = issue ? pc[2] : 1'b1;
    assign isram_csn1 = !issue;
`else
    assign isram_csn0 = !issue;
    assign isram_csn1 = !issue;
`endif

    // Turn the returning word into queue entries.  The low instruction always
    // goes first so the queue stays in program order; a high-only read puts
    // its single instruction in the first slot.
    always_comb begin
        push_first  = inflight && !redirect_valid && !rst;
        push_second = push_first && (infl_lane == LANE_BOTH);
        second_entry = '{pc:    infl_pc + 32'd4,
                         instr: isram_dout[BANK_HI*ILEN +: ILEN]};
        if (infl_lane == LANE_BOTH) begin
            first_entry = '{pc:    infl_pc,
                            instr: isram_dout[BANK_LO*ILEN +: ILEN]};
        end else begin
            first_entry = second_entry;
        end
    end

    assign pop = instr_valid && instr_ready;

    // Fetch state.  Reset beats redirect, and redirect beats a new read; a
    // redirect also forgets the read in flight so its data is never pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC & 32'hFFFF_FFFC;
            inflight  <= 1'b0;
            infl_lane <= LANE_BOTH;
            infl_pc   <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
        end else if (issue) begin
            pc        <= next_fetch_pc(pc);
            inflight  <= 1'b1;
            infl_lane <= pc[2] ? LANE_HI : LANE_BOTH;
            infl_pc   <= word_base(pc);
        end else begin
            inflight <= 1'b0;
        end
    end

    isfetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush        (redirect_valid),
        .push_first   (push_first),
        .push_second  (push_second),
        .first_entry  (first_entry),
        .second_entry (second_entry),
        .pop          (pop),
        .head         (head),
        .count        (count)
    );

    assign instr_valid = (count != '0);
    assign instr_data  = head.instr;
    assign instr_pc    = head.pc;

endmodule
